ram_bist_initiator: RTL and testbench

- Requester side of the RAM's write/read request-acknowledge interface.
- On start, sweeps every RAM index: writes a seed-derived pattern, reads it back, compares, and reports pass/fail, error count and first failing index.
- Sits between SoC control/status logic and the ram instance; drives the wr/rd request ports and consumes the ack ports.

---
 rtl/ram_bist_pkg.sv | 24 ++
 rtl/ram_bist_initiator_if.sv | 26 ++
 rtl/ram_bist_timeout.sv | 25 ++
 rtl/ram_bist_initiator.sv | 154 +++++++++++++++
 tb/tb_ram_bist_initiator.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_bist_pkg.sv
// rtl/ram_bist_pkg.sv - state type, depth constant and pattern function for the RAM BIST initiator
package ram_bist_pkg;

  localparam int INDEX_WIDTH_DEF = 4;
  localparam int DEPTH = 2 ** INDEX_WIDTH_DEF;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_GAP,
    RD_REQ,
    RD_GAP,
    DONE
  } bist_state_e;

  // Computed at 32 bits; callers truncate to their word width.
  function automatic logic [31:0] pat(input logic [31:0] seed, input logic [31:0] index,
                                      input logic inv);
    logic [31:0] p;
    p = seed ^ index;
    return inv ? ~p : p;
  endfunction

endpackage

// File: rtl/ram_bist_initiator_if.sv
// rtl/ram_bist_initiator_if.sv - write/read request-acknowledge bus between BIST initiator and RAM
interface ram_bist_initiator_if #(
  parameter int WORD_WIDTH  = 4,
  parameter int INDEX_WIDTH = 4
);

  logic                   wr_o;
  logic                   ack_wr_i;
  logic [WORD_WIDTH-1:0]  wr_data_o;
  logic [INDEX_WIDTH-1:0] wr_index_o;
  logic                   rd_o;
  logic                   ack_rd_i;
  logic [WORD_WIDTH-1:0]  rd_data_i;
  logic [INDEX_WIDTH-1:0] rd_index_o;

  modport master (
    output wr_o, wr_data_o, wr_index_o, rd_o, rd_index_o,
    input  ack_wr_i, ack_rd_i, rd_data_i
  );

  modport slave (
    input  wr_o, wr_data_o, wr_index_o, rd_o, rd_index_o,
    output ack_wr_i, ack_rd_i, rd_data_i
  );

endinterface

// File: rtl/ram_bist_timeout.sv
// rtl/ram_bist_timeout.sv - request ack timeout down-counter; expired in the TIMEOUT_CYC-th request cycle
module ram_bist_timeout #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic restart_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i || restart_i) begin
      cnt <= CW'(TIMEOUT_CYC - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign expired_o = (cnt == '0);

endmodule

// File: rtl/ram_bist_initiator.sv
// rtl/ram_bist_initiator.sv - RAM write/readback BIST sweep; RAM_BIST_INV_PASS_EN adds an inverted second pass
module ram_bist_initiator
  import ram_bist_pkg::*;
#(
  parameter int WORD_WIDTH    = 4,
  parameter int INDEX_WIDTH   = 4,
  parameter int TIMEOUT_CYC   = 16,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [WORD_WIDTH-1:0]    seed_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     pass_o,
  output logic                     timeout_o,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt_o,
  output logic [INDEX_WIDTH-1:0]   err_index_o,
  ram_bist_initiator_if.master     ram
);

  bist_state_e            state;
  logic [INDEX_WIDTH-1:0] idx;
  logic [WORD_WIDTH-1:0]  seed_q;
  logic [WORD_WIDTH-1:0]  pat_cur;
  logic                   wr_q;
  logic                   rd_q;
  logic                   phase;
  logic                   last_phase;
  logic                   restart;
  logic                   expired;

`ifdef RAM_BIST_INV_PASS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase <= 1'b0;
    end else if (state == IDLE && start_i) begin
      phase <= 1'b0;
    end else if (state == RD_GAP && (&idx)) begin
      phase <= 1'b1;
    end
  end
  assign last_phase = phase;
`else
  assign phase      = 1'b0;
  assign last_phase = 1'b1;
`endif

  assign pat_cur = WORD_WIDTH'(pat(32'(seed_q), 32'(idx), phase));
  assign busy_o  = state inside {WR_REQ, WR_GAP, RD_REQ, RD_GAP};
  assign restart = !(state == WR_REQ || state == RD_REQ);

  ram_bist_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .restart_i (restart),
    .expired_o (expired)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      idx         <= '0;
      seed_q      <= '0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      done_o      <= 1'b0;
      pass_o      <= 1'b0;
      timeout_o   <= 1'b0;
      err_cnt_o   <= '0;
      err_index_o <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            seed_q      <= seed_i;
            err_cnt_o   <= '0;
            err_index_o <= '0;
            timeout_o   <= 1'b0;
            idx         <= '0;
            wr_q        <= 1'b1;
            state       <= WR_REQ;
          end
        end
        WR_REQ: begin
          if (wr_q && ram.ack_wr_i) begin
            wr_q  <= 1'b0;
            state <= WR_GAP;
          end else if (expired) begin
            wr_q      <= 1'b0;
            timeout_o <= 1'b1;
            pass_o    <= 1'b0;
            done_o    <= 1'b1;
            state     <= DONE;
          end
        end
        WR_GAP: begin
          idx <= idx + INDEX_WIDTH'(1);
          if (&idx) begin
            rd_q  <= 1'b1;
            state <= RD_REQ;
          end else begin
            wr_q  <= 1'b1;
            state <= WR_REQ;
          end
        end
        RD_REQ: begin
          if (rd_q && ram.ack_rd_i) begin
            rd_q  <= 1'b0;
            state <= RD_GAP;
            if (ram.rd_data_i != pat_cur) begin
              // A zero count means no earlier mismatch this sweep.
              if (err_cnt_o == '0) err_index_o <= idx;
              if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + ERR_CNT_WIDTH'(1);
            end
          end else if (expired) begin
            rd_q      <= 1'b0;
            timeout_o <= 1'b1;
            pass_o    <= 1'b0;
            done_o    <= 1'b1;
            state     <= DONE;
          end
        end
        RD_GAP: begin
          idx <= idx + INDEX_WIDTH'(1);
          if (&idx) begin
            if (last_phase) begin
              done_o <= 1'b1;
              pass_o <= (err_cnt_o == '0);
              state  <= DONE;
            end else begin
              wr_q  <= 1'b1;
              state <= WR_REQ;
            end
          end else begin
            rd_q  <= 1'b1;
            state <= RD_REQ;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign ram.wr_o       = wr_q;
  assign ram.wr_index_o = idx;
  assign ram.wr_data_o  = pat_cur;
  assign ram.rd_o       = rd_q;
  assign ram.rd_index_o = idx;

endmodule

// File: tb/tb_ram_bist_initiator.sv
// tb/tb_ram_bist_initiator.sv - self-checking bench for ram_bist_initiator with a behavioural RAM model
module tb_ram_bist_initiator;
  import ram_bist_pkg::*;

`ifdef RAM_BIST_INV_PASS_EN
  localparam int PHASES = 2;
`else
  localparam int PHASES = 1;
`endif

  typedef struct {
    logic [3:0] index;
    logic [3:0] data;
  } wr_item_t;

  typedef struct {
    logic       pass;
    logic       timeout;
    logic [7:0] err_cnt;
    logic [3:0] err_index;
    int         busy;
  } res_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] seed = 4'h0;
  logic       busy, done, pass, timeout;
  logic [7:0] err_cnt;
  logic [3:0] err_index;

  ram_bist_initiator_if #(.WORD_WIDTH(4), .INDEX_WIDTH(4)) bus ();

  ram_bist_initiator #(
    .WORD_WIDTH(4), .INDEX_WIDTH(4), .TIMEOUT_CYC(16), .ERR_CNT_WIDTH(8)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .seed_i(seed),
    .busy_o(busy), .done_o(done), .pass_o(pass), .timeout_o(timeout),
    .err_cnt_o(err_cnt), .err_index_o(err_index), .ram(bus)
  );

  always #5 clk = ~clk;

  // RAM model: ack after a per-request latency counted from the first request cycle.
  logic [3:0] mem [DEPTH];
  int  wcyc, wlat, rcyc, rlat;
  bit  lat_rand = 1'b0, fault_en = 1'b0, block_en = 1'b0, mon_en = 1'b0;

  assign bus.ack_wr_i  = bus.wr_o && (wcyc >= wlat) && !(block_en && bus.wr_index_o == 4'd2);
  assign bus.ack_rd_i  = bus.rd_o && (rcyc >= rlat);
  assign bus.rd_data_i = mem[bus.rd_index_o] ^ {3'b000, fault_en && bus.rd_index_o == 4'd5};

  always @(posedge clk) begin
    if (rst) begin
      wcyc <= 0; rcyc <= 0; wlat <= 1; rlat <= 1;
    end else begin
      if (bus.wr_o && bus.ack_wr_i) begin
        mem[bus.wr_index_o] <= bus.wr_data_o;
        wcyc <= 0;
        wlat <= lat_rand ? int'($urandom_range(0, 5)) : 1;
      end else if (bus.wr_o) wcyc <= wcyc + 1;
      else wcyc <= 0;
      if (bus.rd_o && bus.ack_rd_i) begin
        rcyc <= 0;
        rlat <= lat_rand ? int'($urandom_range(0, 5)) : 1;
      end else if (bus.rd_o) rcyc <= rcyc + 1;
      else rcyc <= 0;
    end
  end

  int checks = 0, errors = 0;
  int busy_cyc, done_cnt, wr2_cyc;
  wr_item_t exp_wr[$];
  res_t exp_res[$];
  logic p_wr = 0, p_ack_wr = 0, p_rd = 0, p_ack_rd = 0;
  logic [3:0] p_wi, p_wd, p_ri;

  task automatic prime(input logic [3:0] s);
    exp_wr.delete();
    for (int p = 0; p < PHASES; p++)
      for (int i = 0; i < DEPTH; i++) begin
        logic [3:0] d;
        d = s ^ 4'(i);
        exp_wr.push_back('{index: 4'(i), data: (p == 1) ? ~d : d});
      end
  endtask

  task automatic sample_cycle();
    wr_item_t e;
    @(negedge clk);
    if (bus.wr_o && bus.ack_wr_i) begin
      checks++;
      if (exp_wr.size() == 0) begin
        errors++;
        $display("FAIL wr_scoreboard: write idx=%0d data=%h, required no write", bus.wr_index_o, bus.wr_data_o);
      end else begin
        e = exp_wr.pop_front();
        if ({bus.wr_index_o, bus.wr_data_o} !== {e.index, e.data}) begin
          errors++;
          $display("FAIL wr_scoreboard: idx/data=%0d/%h, required %0d/%h", bus.wr_index_o, bus.wr_data_o, e.index, e.data);
        end
      end
    end
    if (mon_en) begin
      if (p_wr && !p_ack_wr && bus.wr_o) begin
        checks++;
        if ({bus.wr_index_o, bus.wr_data_o} !== {p_wi, p_wd}) begin
          errors++;
          $display("FAIL wr_stable: idx/data=%0d/%h, required %0d/%h", bus.wr_index_o, bus.wr_data_o, p_wi, p_wd);
        end
      end
      if (p_rd && !p_ack_rd && bus.rd_o) begin
        checks++;
        if (bus.rd_index_o !== p_ri) begin
          errors++;
          $display("FAIL rd_stable: idx=%0d, required %0d", bus.rd_index_o, p_ri);
        end
      end
      if ((p_wr && p_ack_wr) || (p_rd && p_ack_rd)) begin
        checks++;
        if ({bus.wr_o, bus.rd_o} !== 2'b00) begin
          errors++;
          $display("FAIL gap_cycle: wr/rd=%b, required 00", {bus.wr_o, bus.rd_o});
        end
      end
    end
    busy_cyc += int'(busy);
    done_cnt += int'(done);
    if (bus.wr_o && bus.wr_index_o == 4'd2) wr2_cyc++;
    p_wr = bus.wr_o; p_ack_wr = bus.ack_wr_i; p_wi = bus.wr_index_o; p_wd = bus.wr_data_o;
    p_rd = bus.rd_o; p_ack_rd = bus.ack_rd_i; p_ri = bus.rd_index_o;
  endtask

  task automatic run_sweep(input logic [3:0] s, input int restart_at);
    res_t r;
    int n;
    prime(s);
    busy_cyc = 0; done_cnt = 0; wr2_cyc = 0; n = 0;
    start = 1'b1; seed = s;
    sample_cycle();
    start = 1'b0;
    while (done_cnt == 0 && n < 2000) begin
      if (n == restart_at) begin start = 1'b1; seed = ~s; end
      sample_cycle();
      start = 1'b0;
      n++;
    end
    repeat (3) sample_cycle();
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL done_pulses: %0d, required 1", done_cnt); end
    if (exp_res.size() == 0) begin
      checks++; errors++;
      $display("FAIL result_queue: empty, required an expected result");
    end else begin
      r = exp_res.pop_front();
      checks++;
      if (pass !== r.pass) begin errors++; $display("FAIL pass: %b, required %b", pass, r.pass); end
      checks++;
      if (timeout !== r.timeout) begin errors++; $display("FAIL timeout: %b, required %b", timeout, r.timeout); end
      checks++;
      if (err_cnt !== r.err_cnt) begin errors++; $display("FAIL err_cnt: %0d, required %0d", err_cnt, r.err_cnt); end
      checks++;
      if (err_index !== r.err_index) begin errors++; $display("FAIL err_index: %0d, required %0d", err_index, r.err_index); end
      if (r.busy >= 0) begin
        checks++;
        if (busy_cyc !== r.busy) begin errors++; $display("FAIL busy_cycles: %0d, required %0d", busy_cyc, r.busy); end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) sample_cycle();
    checks++;
    if ({busy, done, pass, timeout, bus.wr_o, bus.rd_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: busy/done/pass/timeout/wr/rd=%b, required 000000", {busy, done, pass, timeout, bus.wr_o, bus.rd_o});
    end
    checks++;
    if ({err_cnt, err_index} !== 12'h000) begin
      errors++;
      $display("FAIL reset_err: cnt/index=%0d/%0d, required 0/0", err_cnt, err_index);
    end
    rst = 1'b0;
    sample_cycle();
  endtask

  task automatic test_fault_free();
    exp_res.push_back('{pass: 1'b1, timeout: 1'b0, err_cnt: 8'd0, err_index: 4'd0, busy: 96 * PHASES});
    run_sweep(4'hA, -1);
    checks++;
    if (mem[3] !== ((PHASES == 2) ? 4'h6 : 4'h9)) begin
      errors++;
      $display("FAIL mem_index3: %h, required %h", mem[3], (PHASES == 2) ? 4'h6 : 4'h9);
    end
  endtask

  task automatic test_mismatch();
    fault_en = 1'b1;
    exp_res.push_back('{pass: 1'b0, timeout: 1'b0, err_cnt: 8'(PHASES), err_index: 4'd5, busy: 96 * PHASES});
    run_sweep(4'h3, -1);
    fault_en = 1'b0;
  endtask

  task automatic test_timeout();
    block_en = 1'b1;
    exp_res.push_back('{pass: 1'b0, timeout: 1'b1, err_cnt: 8'd0, err_index: 4'd0, busy: 22});
    run_sweep(4'h7, -1);
    checks++;
    if (wr2_cyc !== 16) begin errors++; $display("FAIL timeout_wr_cycles: %0d, required 16", wr2_cyc); end
    block_en = 1'b0;
  endtask

  task automatic test_restart_ignored();
    exp_res.push_back('{pass: 1'b1, timeout: 1'b0, err_cnt: 8'd0, err_index: 4'd0, busy: 96 * PHASES});
    run_sweep(4'hC, 40);
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    prime(4'h5);
    start = 1'b1; seed = 4'h5;
    sample_cycle();
    start = 1'b0;
    n = 0;
    while (!bus.rd_o && n < 200) begin sample_cycle(); n++; end
    checks++;
    if (bus.rd_o !== 1'b1) begin errors++; $display("FAIL reach_rd_req: rd=%b, required 1", bus.rd_o); end
    rst = 1'b1; done_cnt = 0;
    sample_cycle();
    checks++;
    if ({bus.wr_o, bus.rd_o, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid_sweep: wr/rd/busy/done=%b, required 0000", {bus.wr_o, bus.rd_o, busy, done});
    end
    rst = 1'b0;
    repeat (5) sample_cycle();
    checks++;
    if (done_cnt !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_done: done pulses/busy=%0d/%b, required 0/0", done_cnt, busy);
    end
  endtask

  task automatic test_random_latency();
    lat_rand = 1'b1; mon_en = 1'b1;
    exp_res.push_back('{pass: 1'b1, timeout: 1'b0, err_cnt: 8'd0, err_index: 4'd0, busy: -1});
    run_sweep(4'h3, -1);
    exp_res.push_back('{pass: 1'b1, timeout: 1'b0, err_cnt: 8'd0, err_index: 4'd0, busy: -1});
    run_sweep(4'hE, -1);
    lat_rand = 1'b0; mon_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fault_free();
    test_mismatch();
    test_timeout();
    test_restart_ignored();
    test_reset_mid_sweep();
    test_random_latency();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
